// File: rtl/lut_cfg_seq_if.sv
// Control, word-stream and serial-configuration signals of the SoftLUT5 bulk loader.
interface lut_cfg_seq_if #(
   parameter int DATA_W     = 32,
   parameter int GATE_SEL_W = 11
);
   logic                  start;
   logic                  abort;
   logic [GATE_SEL_W-1:0] base_gate;
   logic [GATE_SEL_W:0]   num_gates;
   logic [DATA_W-1:0]     s_tdata;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [GATE_SEL_W-1:0] cfg_gate_sel;
   logic                  cfg_ce;
   logic                  cfg_data;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [GATE_SEL_W:0]   gates_done;

   modport master (
      output start, abort, base_gate, num_gates, s_tdata, s_tvalid,
      input  s_tready, cfg_gate_sel, cfg_ce, cfg_data, busy, done, err, gates_done
   );

   modport slave (
      input  start, abort, base_gate, num_gates, s_tdata, s_tvalid,
      output s_tready, cfg_gate_sel, cfg_ce, cfg_data, busy, done, err, gates_done
   );
endinterface

// File: rtl/lut_cfg_seq.sv
// Bulk truth-table loader: shifts one DATA_W word per gate, LSB first, into a range of gates,
// prefetching the next word into a one-entry buffer so consecutive gates shift without bubbles.
module lut_cfg_seq #(
   parameter int TOTAL_GATES = 1512,
   parameter int DATA_W      = 32,
   parameter int GATE_SEL_W  = $clog2(TOTAL_GATES)
) (
   input  logic         ACLK,
   input  logic         ARESET,
   lut_cfg_seq_if.slave bus
);
   localparam int CNT_W = GATE_SEL_W + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [GATE_SEL_W+1:0] TOTAL_EXT = (GATE_SEL_W+2)'(TOTAL_GATES);
   localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_DONE} state_t;

   state_t                state;
   logic [GATE_SEL_W-1:0] base_q;
   logic [CNT_W-1:0]      num_q;
   logic [CNT_W-1:0]      accepted;
   logic [CNT_W-1:0]      gates_done;
   logic [DATA_W-1:0]     buf_dat;
   logic                  buf_vld;
   logic [DATA_W-1:0]     shreg;
   logic [BIT_W-1:0]      bit_cnt;
   logic [GATE_SEL_W-1:0] gate_sel;
   logic                  cfg_ce;
   logic                  cfg_data;
   logic                  done;
   logic                  err;

   logic [GATE_SEL_W+1:0] end_idx;
   logic                  range_bad;
   logic                  tready;
   logic                  hs;

   // Range check is done two bits wider than the index so base+num can never wrap.
   assign end_idx   = {2'b00, bus.base_gate} + {1'b0, bus.num_gates};
   assign range_bad = (bus.num_gates == '0) || (end_idx > TOTAL_EXT);
   assign tready    = ((state == ST_WAIT) || (state == ST_SHIFT)) && !buf_vld && (accepted < num_q);
   assign hs        = bus.s_tvalid && tready;

   assign bus.s_tready     = tready;
   assign bus.busy         = (state != ST_IDLE);
   assign bus.cfg_gate_sel = gate_sel;
   assign bus.cfg_ce       = cfg_ce;
   assign bus.cfg_data     = cfg_data;
   assign bus.done         = done;
   assign bus.err          = err;
   assign bus.gates_done   = gates_done;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state      <= ST_IDLE;
         base_q     <= '0;
         num_q      <= '0;
         accepted   <= '0;
         gates_done <= '0;
         buf_dat    <= '0;
         buf_vld    <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         gate_sel   <= '0;
         cfg_ce     <= 1'b0;
         cfg_data   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (bus.abort && (state != ST_IDLE)) begin
            state    <= ST_IDLE;
            cfg_ce   <= 1'b0;
            cfg_data <= 1'b0;
            buf_vld  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     if (range_bad) begin
                        err <= 1'b1;
                     end else begin
                        base_q     <= bus.base_gate;
                        num_q      <= bus.num_gates;
                        gates_done <= '0;
                        accepted   <= '0;
                        state      <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (buf_vld) begin
                     shreg    <= buf_dat >> 1;
                     cfg_data <= buf_dat[0];
                     cfg_ce   <= 1'b1;
                     bit_cnt  <= '0;
                     gate_sel <= base_q + gates_done[GATE_SEL_W-1:0];
                     buf_vld  <= 1'b0;
                     state    <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  cfg_data <= shreg[0];
                  shreg    <= shreg >> 1;
                  bit_cnt  <= bit_cnt + BIT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     gates_done <= gates_done + CNT_ONE;
                     if ((gates_done + CNT_ONE) == num_q) begin
                        cfg_ce   <= 1'b0;
                        cfg_data <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                     end else if (buf_vld) begin
                        // Prefetched word is ready: next gate starts on the very next cycle.
                        shreg    <= buf_dat >> 1;
                        cfg_data <= buf_dat[0];
                        bit_cnt  <= '0;
                        gate_sel <= gate_sel + GATE_SEL_W'(1);
                        buf_vld  <= 1'b0;
                     end else begin
                        cfg_ce   <= 1'b0;
                        cfg_data <= 1'b0;
                        state    <= ST_WAIT;
                     end
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
            // A fill on the same edge as a consume leaves the buffer holding the new word.
            if (hs) begin
               buf_dat  <= bus.s_tdata;
               buf_vld  <= 1'b1;
               accepted <= accepted + CNT_ONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_lut_cfg_seq.sv
// Directed bench for lut_cfg_seq: a per-cycle reference model of the load rules plus
// hand-computed expectations for each scenario.
module tb_lut_cfg_seq;
   localparam int TOTAL_GATES = 1512;
   localparam int DATA_W      = 32;
   localparam int GATE_SEL_W  = $clog2(TOTAL_GATES);

   logic ACLK = 1'b0;
   logic ARESET;

   lut_cfg_seq_if #(.DATA_W(DATA_W), .GATE_SEL_W(GATE_SEL_W)) bus ();

   lut_cfg_seq #(.TOTAL_GATES(TOTAL_GATES), .DATA_W(DATA_W), .GATE_SEL_W(GATE_SEL_W)) dut (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .bus   (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {bus.busy, bus.cfg_ce, bus.cfg_data, bus.done, bus.err, bus.s_tready,
              bus.cfg_gate_sel, bus.gates_done};
   endfunction

   // ---------------- word source ----------------
   logic [31:0] src_q[$];
   int          src_gap[$];

   initial begin : source
      bit hs_now;
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      forever begin
         @(negedge ACLK);
         hs_now = bus.s_tvalid && bus.s_tready;
         @(posedge ACLK);
         #1;
         if (hs_now && src_q.size() > 0) begin
            void'(src_q.pop_front());
            void'(src_gap.pop_front());
         end
         if (src_q.size() > 0) begin
            if (src_gap[0] > 0) begin
               src_gap[0]   = src_gap[0] - 1;
               bus.s_tvalid = 1'b0;
            end else begin
               bus.s_tvalid = 1'b1;
               bus.s_tdata  = src_q[0];
            end
         end else begin
            bus.s_tvalid = 1'b0;
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_busy, m_err;
   int          m_base, m_num, ce_cnt, hs_cnt, last_sel;
   logic [31:0] m_words[$];
   logic        prev_ce;

   initial begin : compare
      bit exp_done;
      int g;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            m_busy = 0; m_err = 0; m_base = 0; m_num = 0;
            ce_cnt = 0; hs_cnt = 0; last_sel = 0; prev_ce = 1'b0;
            m_words.delete();
         end else begin
            exp_done = m_busy && prev_ce && (ce_cnt == 32 * m_num);
            chk("busy", bus.busy, m_busy);
            chk("err", bus.err, m_err);
            chk("done", bus.done, exp_done);
            chk("gates_done", bus.gates_done, ce_cnt / 32);
            if (!m_busy || exp_done) chk("ce_outside_load", bus.cfg_ce, 0);
            if (!bus.cfg_ce) begin
               chk("cfg_data_idle", bus.cfg_data, 0);
               chk("gate_sel_hold", bus.cfg_gate_sel, last_sel);
            end else begin
               g = ce_cnt / 32;
               if (g < m_words.size()) begin
                  chk("cfg_data", bus.cfg_data, m_words[g][ce_cnt % 32]);
                  chk("gate_sel", bus.cfg_gate_sel, m_base + g);
               end else begin
                  chk("ce_without_word", g, m_words.size());
               end
               last_sel = m_base + g;
               ce_cnt++;
            end
            if (!m_busy || hs_cnt >= m_num) chk("tready_off", bus.s_tready, 0);
            if (bus.s_tvalid && bus.s_tready) begin
               m_words.push_back(bus.s_tdata);
               hs_cnt++;
            end
            prev_ce = bus.cfg_ce;
            m_err = 0;
            if (!m_busy) begin
               if (bus.start) begin
                  if (bus.num_gates == 0 ||
                      int'(bus.base_gate) + int'(bus.num_gates) > TOTAL_GATES) begin
                     m_err = 1;
                  end else begin
                     m_busy = 1; m_base = bus.base_gate; m_num = bus.num_gates;
                     ce_cnt = 0; hs_cnt = 0; m_words.delete();
                  end
               end
            end else if (bus.abort || exp_done) begin
               m_busy = 0;
            end
         end
      end
   end

   // ---------------- scenario statistics ----------------
   int   ce_tot, hs_tot, done_tot, err_tot, busy_tot, cur_run, max_run, cur_gap, max_gap;
   bit   seen_ce;
   logic bitlog[$];
   int   sellog[$];

   task automatic clear_stats();
      ce_tot = 0; hs_tot = 0; done_tot = 0; err_tot = 0; busy_tot = 0;
      cur_run = 0; max_run = 0; cur_gap = 0; max_gap = 0; seen_ce = 0;
      bitlog.delete(); sellog.delete();
   endtask

   initial begin : monitor
      clear_stats();
      forever begin
         @(negedge ACLK);
         if (!ARESET) begin
            if (bus.cfg_ce) begin
               ce_tot++;
               bitlog.push_back(bus.cfg_data);
               sellog.push_back(int'(bus.cfg_gate_sel));
               if (seen_ce && cur_gap > max_gap) max_gap = cur_gap;
               cur_gap = 0; seen_ce = 1; cur_run++;
               if (cur_run > max_run) max_run = cur_run;
            end else begin
               cur_run = 0;
               if (bus.busy && seen_ce) cur_gap++;
            end
            if (bus.s_tvalid && bus.s_tready) hs_tot++;
            if (bus.done) done_tot++;
            if (bus.err) err_tot++;
            if (bus.busy) busy_tot++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_start(input int b, input int n);
      bus.base_gate = GATE_SEL_W'(b);
      bus.num_gates = (GATE_SEL_W+1)'(n);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w, input int gap);
      src_q.push_back(w);
      src_gap.push_back(gap);
   endtask

   task automatic flush_src();
      tick();
      src_q.delete();
      src_gap.delete();
      tick();
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (bus.busy && k < budget) begin tick(); k++; end
      if (bus.busy) begin
         n_vec++; n_err++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
      end
      tick();
   endtask

   task automatic wait_ce(input int target, input int budget, input string name);
      int k = 0;
      while (ce_tot < target && k < budget) begin tick(); k++; end
      if (ce_tot < target) begin
         n_vec++; n_err++;
         $display("FAIL %s: %0d cfg_ce cycles, expected %0d", name, ce_tot, target);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      logic [31:0] w;
      int c10, c11, c12;
      bus.start = 1'b0; bus.abort = 1'b0; bus.base_gate = '0; bus.num_gates = '0;
      ARESET = 1'b1;
      repeat (3) tick();
      chk("reset_outputs", outs(), 0);
      #3 ARESET = 1'b0;
      tick();
      chk("post_reset_outputs", outs(), 0);

      // single gate: base 5, 0xA5A50F0F
      clear_stats();
      push_word(32'hA5A50F0F, 0);
      do_start(5, 1);
      wait_idle(200, "t1_timeout");
      w = '0;
      for (int i = 0; i < 32 && i < bitlog.size(); i++) w[i] = bitlog[i];
      chk("t1_nbits", bitlog.size(), 32);
      chk("t1_bits", w, 32'hA5A50F0F);
      chk("t1_sel", (sellog.size() > 0) ? sellog[0] : -1, 5);
      chk("t1_run", max_run, 32);
      chk("t1_done", done_tot, 1);
      chk("t1_gates_done", bus.gates_done, 1);

      // back-to-back: base 10, 3 gates, valid held with a surplus word
      clear_stats();
      push_word(32'h11111111, 0);
      push_word(32'h80000001, 0);
      push_word(32'hDEADBEEF, 0);
      push_word(32'h12345678, 0);
      do_start(10, 3);
      wait_ce(40, 200, "t2_progress");
      do_start(0, 0);
      wait_idle(300, "t2_timeout");
      c10 = 0; c11 = 0; c12 = 0;
      foreach (sellog[i]) begin
         if (sellog[i] == 10) c10++;
         if (sellog[i] == 11) c11++;
         if (sellog[i] == 12) c12++;
      end
      chk("t2_run", max_run, 96);
      chk("t2_ce_total", ce_tot, 96);
      chk("t2_sel10", c10, 32);
      chk("t2_sel11", c11, 32);
      chk("t2_sel12", c12, 32);
      chk("t2_handshakes", hs_tot, 3);
      chk("t2_done", done_tot, 1);
      chk("t2_err", err_tot, 0);
      flush_src();

      // stall: second word arrives late
      clear_stats();
      push_word(32'hF0F0F0F0, 0);
      push_word(32'h0000FFFF, 60);
      do_start(100, 2);
      wait_idle(400, "t3_timeout");
      chk("t3_gap_ge_20", (max_gap >= 20), 1);
      chk("t3_ce_total", ce_tot, 64);
      chk("t3_done", done_tot, 1);
      chk("t3_gates_done", bus.gates_done, 2);

      // range rejects, with a word waiting on the stream
      clear_stats();
      push_word(32'hCAFEF00D, 0);
      do_start(1510, 3);
      repeat (3) tick();
      chk("t4_err_range", err_tot, 1);
      chk("t4_busy", busy_tot, 0);
      chk("t4_ce", ce_tot, 0);
      chk("t4_hs", hs_tot, 0);
      clear_stats();
      do_start(0, 0);
      repeat (3) tick();
      chk("t4_err_zero", err_tot, 1);
      chk("t4_busy_zero", busy_tot, 0);
      flush_src();

      // last legal gate
      clear_stats();
      push_word(32'h0000FFFF, 0);
      do_start(1511, 1);
      wait_idle(200, "t4b_timeout");
      chk("t4b_err", err_tot, 0);
      chk("t4b_done", done_tot, 1);
      chk("t4b_sel", (sellog.size() > 0) ? sellog[0] : -1, 1511);

      // abort at bit 12 of gate 1 of 4
      clear_stats();
      for (int i = 0; i < 4; i++) push_word(32'h9E3779B9 * (i + 1), 0);
      do_start(20, 4);
      wait_ce(44, 200, "t5_progress");
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t5_busy", bus.busy, 0);
      chk("t5_ce", bus.cfg_ce, 0);
      chk("t5_gates_done", bus.gates_done, 1);
      chk("t5_done", done_tot, 0);
      flush_src();
      clear_stats();
      push_word(32'h00FF00FF, 0);
      push_word(32'h55AA55AA, 0);
      do_start(30, 2);
      wait_idle(300, "t5b_timeout");
      chk("t5b_done", done_tot, 1);
      chk("t5b_gates_done", bus.gates_done, 2);

      // asynchronous reset mid-shift
      clear_stats();
      push_word(32'hFFFFFFFF, 0);
      push_word(32'hFFFFFFFF, 0);
      do_start(40, 2);
      wait_ce(10, 200, "t6_progress");
      #3 ARESET = 1'b1;
      #1 chk("t6_async_reset", outs(), 0);
      tick();
      tick();
      #3 ARESET = 1'b0;
      flush_src();
      clear_stats();
      push_word(32'h13579BDF, 0);
      do_start(50, 1);
      wait_idle(200, "t6b_timeout");
      chk("t6b_done", done_tot, 1);
      chk("t6b_gates_done", bus.gates_done, 1);
      chk("t6b_sel", (sellog.size() > 0) ? sellog[0] : -1, 50);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
